// File: rtl/hub75_pkg.sv
// hub75_pkg: shared state encoding, pixel-word field layout and width helpers for the HUB75 driver.
package hub75_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_DISP, LATCH} state_e;
  // Field index within the pixel word {r1,g1,b1,r2,g2,b2}; offset = index * COLOR_BITS.
  localparam int F_R1 = 5;
  localparam int F_G1 = 4;
  localparam int F_B1 = 3;
  localparam int F_R2 = 2;
  localparam int F_G2 = 1;
  localparam int F_B2 = 0;
  localparam int N_FIELDS = 6;
  function automatic int clog2w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int timer_w(input int base_on, input int color_bits);
    return $clog2(256 * base_on * (1 << (color_bits - 1)) + 1);
  endfunction
endpackage

// File: rtl/hub75_plane_timer.sv
// hub75_plane_timer: loadable on-time down-counter; zero_o drives panel blanking.
module hub75_plane_timer #(
  parameter int TW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          zero_o
);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: HUB75 panel scanner with binary-coded modulation; shifts plane N+1 while plane N is lit.
module hub75_bcm_driver
  import hub75_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int SCAN_ROWS    = 32,
  parameter int COLOR_BITS   = 4,
  parameter int BASE_ON      = 8,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic [7:0]                    brightness_i,
  output logic                          pix_rd_o,
  output logic [clog2w(SCAN_ROWS)-1:0]  pix_row_o,
  output logic [clog2w(WIDTH)-1:0]      pix_x_o,
  input  logic [6*COLOR_BITS-1:0]       pix_data_i,
  output logic                          r1_o,
  output logic                          g1_o,
  output logic                          b1_o,
  output logic                          r2_o,
  output logic                          g2_o,
  output logic                          b2_o,
  output logic [4:0]                    abcde_o,
  output logic                          clk_o,
  output logic                          lat_o,
  output logic                          oe_o,
  output logic                          frame_done_o
);
  localparam int XW = clog2w(WIDTH);
  localparam int RW = clog2w(SCAN_ROWS);
  localparam int PW = clog2w(COLOR_BITS);
  localparam int LW = clog2w(BLANK_CYCLES);
  localparam int TW = timer_w(BASE_ON, COLOR_BITS);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(SCAN_ROWS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(COLOR_BITS - 1);
  localparam logic [LW-1:0] L_LAST = LW'(BLANK_CYCLES - 1);

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, rd_x;
  logic            ph_q, ph_d, pend_q, pend_d, rd, t_zero, lat_last;
  logic [RW-1:0]   row_q, row_d, prow_q, prow_d;
  logic [PW-1:0]   pl_q, pl_d, ppl_q, ppl_d;
  logic [LW-1:0]   lc_q, lc_d;
  logic [4:0]      abcde_q, abcde_d;
  logic [5:0]      rgb_q, rgb_d, rgb_cur, rgb;
  logic [TW-1:0]   load_val;

  for (genvar i = 0; i < N_FIELDS; i++) begin : g_fld
    logic [COLOR_BITS-1:0] fld;
    assign fld = pix_data_i[i*COLOR_BITS +: COLOR_BITS];
    assign rgb_cur[i] = fld[pl_q];
  end

  assign lat_last = (state_q == LATCH) && (lc_q == L_LAST);
  assign load_val = TW'(((32'(brightness_i) + 32'd1) * 32'(BASE_ON)) << ppl_q);

  hub75_plane_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lat_last),
    .load_val_i (load_val),
    .zero_o     (t_zero)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ph_d    = ph_q;
    row_d   = row_q;
    pl_d    = pl_q;
    prow_d  = prow_q;
    ppl_d   = ppl_q;
    pend_d  = pend_q;
    lc_d    = lc_q;
    abcde_d = abcde_q;
    rgb_d   = rgb_q;
    rd      = 1'b0;
    rd_x    = '0;
    case (state_q)
      IDLE: begin
        rd = enable_i;
        if (enable_i) begin
          state_d = SHIFT;
          x_d     = '0;
          ph_d    = 1'b0;
        end
      end
      SHIFT: begin
        ph_d = !ph_q;
        if (!ph_q) rgb_d = rgb_cur;
        else if (x_q == X_LAST) begin
          // Row shifted: remember what awaits latching, advance the shift pointer.
          state_d = WAIT_DISP;
          pend_d  = 1'b1;
          prow_d  = row_q;
          ppl_d   = pl_q;
          pl_d    = (pl_q == P_LAST) ? '0 : pl_q + 1'b1;
          row_d   = (pl_q != P_LAST) ? row_q : (row_q == R_LAST) ? '0 : row_q + 1'b1;
        end else begin
          x_d  = x_q + 1'b1;
          rd   = 1'b1;
          rd_x = x_q + 1'b1;
        end
      end
      WAIT_DISP: begin
        if (t_zero) begin
          state_d = pend_q ? LATCH : IDLE;
          lc_d    = '0;
        end
      end
      LATCH: begin
        lc_d = lc_q + 1'b1;
        if (lc_q == '0) abcde_d = 5'(prow_q);
        if (lc_q == L_LAST) begin
          state_d = enable_i ? SHIFT : WAIT_DISP;
          rd      = enable_i;
          pend_d  = 1'b0;
          lc_d    = '0;
          x_d     = '0;
          ph_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      ph_q    <= 1'b0;
      row_q   <= '0;
      pl_q    <= '0;
      prow_q  <= '0;
      ppl_q   <= '0;
      pend_q  <= 1'b0;
      lc_q    <= '0;
      abcde_q <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ph_q    <= ph_d;
      row_q   <= row_d;
      pl_q    <= pl_d;
      prow_q  <= prow_d;
      ppl_q   <= ppl_d;
      pend_q  <= pend_d;
      lc_q    <= lc_d;
      abcde_q <= abcde_d;
      rgb_q   <= rgb_d;
    end
  end

  // Fetched data arrives in the slot's first clock, so it is passed through then and held for the second.
  assign rgb          = (state_q == SHIFT && !ph_q) ? rgb_cur : rgb_q;
  assign {r1_o, g1_o, b1_o} = {rgb[F_R1], rgb[F_G1], rgb[F_B1]};
  assign {r2_o, g2_o, b2_o} = {rgb[F_R2], rgb[F_G2], rgb[F_B2]};
  assign clk_o        = (state_q == SHIFT) && ph_q;
  assign lat_o        = (state_q == LATCH) && (lc_q == LW'(1));
  assign oe_o         = t_zero;
  assign abcde_o      = abcde_q;
  assign frame_done_o = lat_last && (prow_q == R_LAST) && (ppl_q == P_LAST);
  assign pix_rd_o     = rd && rst_n;
  assign pix_row_o    = row_q;
  assign pix_x_o      = rd_x;
endmodule
